// File: rtl/gbsha_fir_prog_if.sv
// Sample/coefficient/result bundle for the programmable FIR.
// Latency: none, wires only.
// Backpressure: x_ready from the filter gates x_valid; results are pushed with no ready.
//
// Ports (master = sample/coefficient source, slave = filter):
//   x_in, x_valid, coef_start, coef_wr, coef_in : master -> slave
//   x_ready, y_out, y_valid, ovf               : slave  -> master
interface gbsha_fir_prog_if #(
    parameter int BW_in   = 4,
    parameter int BW_coef = 4,
    parameter int BW_out  = 6
);
    logic signed [BW_in-1:0]   x_in;
    logic                      x_valid;
    logic                      x_ready;
    logic                      coef_start;
    logic                      coef_wr;
    logic signed [BW_coef-1:0] coef_in;
    logic signed [BW_out-1:0]  y_out;
    logic                      y_valid;
    logic                      ovf;

    modport master (
        output x_in, x_valid, coef_start, coef_wr, coef_in,
        input  x_ready, y_out, y_valid, ovf
    );

    modport slave (
        input  x_in, x_valid, coef_start, coef_wr, coef_in,
        output x_ready, y_out, y_valid, ovf
    );
endinterface

// File: rtl/gbsha_fir_prog.sv
// Transposed-form FIR with run-time loadable coefficients, round-and-saturate output, sticky overflow.
// Latency: 1 cycle, sample accepted at edge E gives y_out/y_valid in the cycle after E.
// Backpressure: x_ready high only in RUN; samples are refused while loading or flushing.
//
// Ports: clk, reset (async active-low); bus (slave modport of gbsha_fir_prog_if) carries
//   x_in/x_valid/x_ready, coef_start/coef_wr/coef_in, y_out/y_valid/ovf.
module gbsha_fir_prog #(
    parameter int N_TAPS  = 4,
    parameter int BW_in   = 4,
    parameter int BW_coef = 4,
    parameter int BW_out  = 6,
    parameter int SHIFT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    gbsha_fir_prog_if.slave   bus
);
    localparam int BW_product = BW_in + BW_coef;
    localparam int BW_acc     = BW_product + $clog2(N_TAPS);
    localparam int IDX_W      = $clog2(N_TAPS);

    localparam logic signed [BW_out-1:0] Y_MAX = {1'b0, {(BW_out-1){1'b1}}};
    localparam logic signed [BW_out-1:0] Y_MIN = {1'b1, {(BW_out-1){1'b0}}};
    localparam logic signed [BW_acc:0]   SAT_HI = (BW_acc+1)'(2**(BW_out-1) - 1);
    localparam logic signed [BW_acc:0]   SAT_LO = (BW_acc+1)'(-(2**(BW_out-1)));

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic signed [BW_coef-1:0]   c    [N_TAPS];
    logic signed [BW_acc-1:0]    acc  [N_TAPS];
    logic signed [BW_product-1:0] prod [N_TAPS];
    logic signed [BW_out-1:0]    y_out_q;
    logic                        y_valid_q;
    logic                        ovf_q;

    // One extra bit over the accumulator so the rounding offset cannot wrap.
    logic signed [BW_acc:0]      tap0_sum;
    logic signed [BW_acc:0]      rnd_v;
    logic signed [BW_out-1:0]    y_sat;
    logic                        sat_hit;

    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            prod[k] = BW_product'(c[k]) * BW_product'(bus.x_in);
        end
    end

    // Output tap: same value acc[0] would take, taken straight to the output register.
    assign tap0_sum = (BW_acc+1)'(prod[0]) + (BW_acc+1)'(acc[1]);

    generate
        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [BW_acc:0] HALF = (BW_acc+1)'(2**(SHIFT-1));
            assign rnd_v = (tap0_sum + HALF) >>> SHIFT;
        end else begin : g_nornd
            assign rnd_v = tap0_sum;
        end
    endgenerate

    always_comb begin
        sat_hit = 1'b0;
        y_sat   = rnd_v[BW_out-1:0];
        if (rnd_v > SAT_HI) begin
            sat_hit = 1'b1;
            y_sat   = Y_MAX;
        end else if (rnd_v < SAT_LO) begin
            sat_hit = 1'b1;
            y_sat   = Y_MIN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            idx       <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                c[k]   <= (k == 0) ? BW_coef'(1) : '0;
                acc[k] <= '0;
            end
        end else begin
            y_valid_q <= 1'b0;
            case (state)
                RUN: begin
                    // A load request wins over a sample on the same edge; the sample is lost.
                    if (bus.coef_start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end else if (bus.x_valid) begin
                        for (int k = 0; k < N_TAPS-1; k++) begin
                            acc[k] <= BW_acc'(prod[k]) + acc[k+1];
                        end
                        acc[N_TAPS-1] <= BW_acc'(prod[N_TAPS-1]);
                        y_out_q       <= y_sat;
                        y_valid_q     <= 1'b1;
                        if (sat_hit) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.coef_start) begin
                        idx <= '0;
                    end else if (bus.coef_wr) begin
                        c[idx] <= bus.coef_in;
                        if (idx == IDX_W'(N_TAPS-1)) begin
                            state <= FLUSH;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Old partial sums were built with the previous coefficients.
                    for (int k = 0; k < N_TAPS; k++) begin
                        acc[k] <= '0;
                    end
                    ovf_q <= 1'b0;
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.x_ready = (state == RUN);
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_gbsha_fir_prog.sv
// Bench for gbsha_fir_prog: directed scenarios plus random traffic against a convolution model.
// Latency: model expects outputs one edge after the accepted sample.
// Backpressure: model tracks RUN/LOAD/FLUSH to predict x_ready and dropped samples.
module tb_gbsha_fir_prog;
    localparam int N  = 4;
    localparam int BI = 4;
    localparam int BC = 4;
    localparam int BO = 6;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic reset;

    gbsha_fir_prog_if #(.BW_in(BI), .BW_coef(BC), .BW_out(BO)) bus ();

    gbsha_fir_prog #(
        .N_TAPS(N), .BW_in(BI), .BW_coef(BC), .BW_out(BO), .SHIFT(SH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: coefficient table, history of accepted samples (newest first),
    // mode 0=run 1=load 2=flush, and the expected visible outputs.
    int m_c [N];
    int m_h [N];
    int m_mode, m_idx, m_y, m_yv, m_ovf;
    int yq [$];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_c[k] = (k == 0) ? 1 : 0;
            m_h[k] = 0;
        end
        m_mode = 0; m_idx = 0; m_y = 0; m_yv = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        int v, r;
        m_yv = 0;
        case (m_mode)
            0: begin
                if (bus.coef_start) begin
                    m_mode = 1; m_idx = 0;
                end else if (bus.x_valid) begin
                    for (int k = N-1; k > 0; k--) m_h[k] = m_h[k-1];
                    m_h[0] = int'(bus.x_in);
                    v = 0;
                    for (int k = 0; k < N; k++) v += m_c[k] * m_h[k];
                    r = (v + (1 << (SH-1))) >>> SH;
                    if (r > 2**(BO-1) - 1) begin r = 2**(BO-1) - 1; m_ovf = 1; end
                    if (r < -(2**(BO-1)))  begin r = -(2**(BO-1));  m_ovf = 1; end
                    m_y = r; m_yv = 1;
                end
            end
            1: begin
                if (bus.coef_start) m_idx = 0;
                else if (bus.coef_wr) begin
                    m_c[m_idx] = int'(bus.coef_in);
                    m_idx++;
                    if (m_idx == N) begin m_mode = 2; m_idx = 0; end
                end
            end
            default: begin
                for (int k = 0; k < N; k++) m_h[k] = 0;
                m_ovf = 0; m_mode = 0;
            end
        endcase
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("y_valid", int'(bus.y_valid), m_yv);
        check("y_out",   int'(bus.y_out),   m_y);
        check("ovf",     int'(bus.ovf),     m_ovf);
        check("x_ready", int'(bus.x_ready), int'(m_mode == 0));
        if (bus.y_valid) yq.push_back(int'(bus.y_out));
    endtask

    task automatic idle();
        bus.x_valid = 1'b0; bus.x_in = '0;
        bus.coef_start = 1'b0; bus.coef_wr = 1'b0; bus.coef_in = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        check("rst_y_out",   int'(bus.y_out),   0);
        check("rst_y_valid", int'(bus.y_valid), 0);
        check("rst_ovf",     int'(bus.ovf),     0);
        check("rst_x_ready", int'(bus.x_ready), 1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic send(input int x);
        bus.x_valid = 1'b1; bus.x_in = BI'(x);
        tick();
        bus.x_valid = 1'b0; bus.x_in = '0;
    endtask

    task automatic wr(input int cv);
        bus.coef_wr = 1'b1; bus.coef_in = BC'(cv);
        tick();
        bus.coef_wr = 1'b0;
    endtask

    task automatic start_load();
        bus.coef_start = 1'b1;
        tick();
        bus.coef_start = 1'b0;
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3);
        start_load();
        wr(c0); wr(c1); wr(c2); wr(c3);
        tick();
    endtask

    task automatic expect_q(input string tag, input int exp [$]);
        check({tag, "_count"}, yq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < yq.size(); i++)
            check($sformatf("%s_%0d", tag, i), yq[i], exp[i]);
        yq.delete();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        do_reset();

        // Identity coefficients out of reset
        yq.delete();
        send(2); send(6); send(-2);
        expect_q("ident", '{1, 2, 0});

        // Impulse through a ramp
        load(1, 2, 3, 4);
        yq.delete();
        send(4); send(0); send(0); send(0); send(0);
        expect_q("ramp", '{1, 2, 3, 4, 0});

        // Positive saturation, sticky ovf, cleared by flush
        load(-8, -8, -8, -8);
        for (int i = 0; i < 6; i++) send(-8);
        check("pos_sat_y", int'(bus.y_out), 31);
        check("pos_sat_ovf", int'(bus.ovf), 1);
        for (int i = 0; i < 6; i++) send(0);
        check("ovf_sticky", int'(bus.ovf), 1);
        load(1, 0, 0, 0);
        check("ovf_flushed", int'(bus.ovf), 0);

        // Negative saturation
        load(7, 7, 7, 7);
        for (int i = 0; i < 6; i++) send(-8);
        check("neg_sat_y", int'(bus.y_out), -32);
        check("neg_sat_ovf", int'(bus.ovf), 1);

        // Restart mid-load
        start_load();
        wr(5); wr(5);
        start_load();
        wr(0); wr(0); wr(0); wr(1);
        tick();
        yq.delete();
        send(4); send(0); send(0); send(0);
        expect_q("restart", '{0, 0, 0, 1});

        // coef_start beats x_valid on the same edge
        bus.coef_start = 1'b1; bus.x_valid = 1'b1; bus.x_in = BI'(3);
        tick();
        idle();
        check("start_prio_no_y", int'(bus.y_valid), 0);
        wr(1); wr(0); wr(0); wr(0);
        tick();

        // Reset mid-load reverts to identity
        start_load();
        wr(3); wr(3);
        do_reset();
        yq.delete();
        send(4);
        expect_q("rst_load", '{1});

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.x_valid    = ($urandom % 4) != 0;
            bus.x_in       = BI'($urandom_range(0, 15));
            bus.coef_start = ($urandom % 60) == 0;
            bus.coef_wr    = ($urandom % 2) == 0;
            bus.coef_in    = BC'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
